// File: rtl/mem_bus_arbiter.sv
// CPU / LCD-fetch arbiter for the shared nibble RAM/VRAM bus.
// Optional video starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 4,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_write_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  cpu_ack,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic                  vid_data_valid,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_done,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int CMAX = (BURST_LEN > STARVE_LIMIT) ? BURST_LEN : STARVE_LIMIT;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ISSUE,
        CPU_DATA,
        VID_BURST,
        VID_DRAIN
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] beat_cnt;
    logic          cpu_we_q;
    logic          iss_v, iss_last;
    logic          ret_v, ret_last;
    logic          cpu_go, vid_go, forced;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [CW-1:0] SL = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt;
    logic          cpu_phase;

    assign forced    = vid_req && !vid_ack && (starve_cnt == SL);
    assign cpu_phase = (state == IDLE) || (state == CPU_ISSUE) || (state == CPU_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (vid_go) begin
            starve_cnt <= '0;
        end else if (vid_req && cpu_phase && starve_cnt != SL) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    assign forced = 1'b0;
`endif

    // A request still held during its ack cycle keeps the bus for the CPU
    always_comb begin
        state_nx = state;
        cpu_go   = 1'b0;
        vid_go   = 1'b0;
        unique case (state)
            IDLE: begin
                if (forced) begin
                    vid_go = 1'b1;
                end else if (cpu_req && !cpu_ack) begin
                    cpu_go = 1'b1;
                end else if (!cpu_req && vid_req && !vid_ack) begin
                    vid_go = 1'b1;
                end
                if (cpu_go) state_nx = CPU_ISSUE;
                if (vid_go) state_nx = VID_BURST;
            end
            CPU_ISSUE: state_nx = CPU_DATA;
            CPU_DATA:  state_nx = IDLE;
            VID_BURST: if (beat_cnt == BL) state_nx = VID_DRAIN;
            VID_DRAIN: if (ret_v && ret_last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            cpu_we_q       <= 1'b0;
            iss_v          <= 1'b0;
            iss_last       <= 1'b0;
            ret_v          <= 1'b0;
            ret_last       <= 1'b0;
            cpu_read_data  <= '0;
            cpu_ack        <= 1'b0;
            vid_ack        <= 1'b0;
            vid_data_valid <= 1'b0;
            vid_data       <= '0;
            vid_done       <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            state          <= state_nx;
            mem_write_en   <= 1'b0;
            cpu_ack        <= 1'b0;
            vid_ack        <= 1'b0;
            vid_data_valid <= 1'b0;
            vid_done       <= 1'b0;
            iss_v          <= 1'b0;
            iss_last       <= 1'b0;
            ret_v          <= iss_v;
            ret_last       <= iss_last;

            if (cpu_go) begin
                mem_addr       <= cpu_addr;
                mem_write_data <= cpu_write_data;
                mem_write_en   <= cpu_write_en;
                cpu_we_q       <= cpu_write_en;
            end

            if (state == CPU_DATA) begin
                cpu_ack <= 1'b1;
                if (!cpu_we_q) cpu_read_data <= mem_read_data;
            end

            if (vid_go) begin
                mem_addr <= vid_addr;
                vid_ack  <= 1'b1;
                beat_cnt <= CW'(1);
                iss_v    <= 1'b1;
                iss_last <= (BL == CW'(1));
            end

            // Beat address wraps naturally at the top of the address space
            if (state == VID_BURST && beat_cnt != BL) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                beat_cnt <= beat_cnt + CW'(1);
                iss_v    <= 1'b1;
                iss_last <= (beat_cnt == BL - CW'(1));
            end

            if (ret_v) begin
                vid_data_valid <= 1'b1;
                vid_data       <= mem_read_data;
                vid_done       <= ret_last;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a 1-cycle registered RAM model.
module tb_mem_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 4;
    localparam int BL = 4;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_write_en = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_write_data = '0;
    logic [DW-1:0] cpu_read_data;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic          vid_data_valid;
    logic [DW-1:0] vid_data;
    logic          vid_done;
    logic          mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;

    logic [DW-1:0] ram [4096];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  q_cpu [$];
    logic [4:0]  q_vid [$];
    logic [15:0] q_wr  [$];

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_LEN(BL), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_write_en(cpu_write_en),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_read_data(cpu_read_data), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_data_valid(vid_data_valid), .vid_data(vid_data),
        .vid_done(vid_done), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) ram[mem_addr] <= mem_write_data;
        mem_read_data <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response
    always @(negedge clk) begin
        if (reset_n) begin
            logic [4:0]  ev;
            logic [15:0] ew;
            if (cpu_ack) begin
                if (q_cpu.size() == 0) check("cpu_ack_unexpected", cpu_ack, 0);
                else check("cpu_read_data", cpu_read_data, q_cpu.pop_front());
            end
            if (vid_data_valid) begin
                if (q_vid.size() == 0) begin
                    check("vid_valid_unexpected", vid_data_valid, 0);
                end else begin
                    ev = q_vid.pop_front();
                    check("vid_data", vid_data, ev[3:0]);
                    check("vid_done_beat", vid_done, ev[4]);
                end
            end
            if (vid_done && !vid_data_valid) check("vid_done_alone", vid_done, 0);
            if (mem_write_en) begin
                if (q_wr.size() == 0) begin
                    check("wr_unexpected", mem_write_en, 0);
                end else begin
                    ew = q_wr.pop_front();
                    check("wr_addr", mem_addr, ew[15:4]);
                    check("wr_data", mem_write_data, ew[3:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_vid(input logic [4*BL-1:0] vals);
        for (int i = 0; i < BL; i++)
            q_vid.push_back({(i == BL - 1), vals[4*i +: 4]});
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                              input logic [3:0] wd, input logic [3:0] exp_rd);
        int n;
        q_cpu.push_back(exp_rd);
        if (we) q_wr.push_back({a, wd});
        cpu_req = 1'b1;
        cpu_write_en = we;
        cpu_addr = a;
        cpu_write_data = wd;
        step();
        check("cpu_mem_addr", mem_addr, a);
        check("cpu_mem_we", mem_write_en, we);
        n = 1;
        while (!cpu_ack && n < 40) begin
            step();
            n++;
        end
        check("cpu_latency", n, 3);
        cpu_req = 1'b0;
        cpu_write_en = 1'b0;
        step();
        check("cpu_ack_width", cpu_ack, 0);
        check("cpu_we_after", mem_write_en, 0);
    endtask

    // Beats after the grant cycle: addresses, valid window, done timing
    task automatic vid_body(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int i = 1; i <= BL + 1; i++) begin
            step();
            a = base + AW'(i);
            if (i < BL) check("vid_addr", mem_addr, a);
            check("vid_valid_time", vid_data_valid, (i >= 2));
            check("vid_done_time", vid_done, (i == BL + 1));
            check("vid_no_write", mem_write_en, 0);
        end
    endtask

    task automatic vid_burst(input logic [AW-1:0] base, input logic [4*BL-1:0] vals);
        push_vid(vals);
        vid_req = 1'b1;
        vid_addr = base;
        step();
        check("vid_ack", vid_ack, 1);
        check("vid_base_addr", mem_addr, base);
        vid_req = 1'b0;
        vid_body(base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int n, cnt, first;
        logic seen;

        for (int i = 0; i < 4096; i++) ram[i] <= '0;
        ram[12'hE00] <= 4'h1; ram[12'hE01] <= 4'h2;
        ram[12'hE02] <= 4'h3; ram[12'hE03] <= 4'h4;
        ram[12'hFFE] <= 4'h5; ram[12'hFFF] <= 4'h6;
        ram[12'h000] <= 4'h7; ram[12'h001] <= 4'h8;
        ram[12'h010] <= 4'h9;
        ram[12'hE40] <= 4'hB; ram[12'hE41] <= 4'hC;
        ram[12'hE42] <= 4'hD; ram[12'hE43] <= 4'hE;

        step();
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_vid_valid", vid_data_valid, 0);
        check("rst_mem_we", mem_write_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rd", cpu_read_data, 0);
        reset_n = 1'b1;
        step();

        cpu_access(1'b1, 12'h123, 4'hA, 4'h0);
        cpu_access(1'b0, 12'h123, 4'h0, 4'hA);

        vid_burst(12'hE00, 16'h4321);

        // Simultaneous requests: CPU first, video on the following IDLE edge
        q_cpu.push_back(4'hA);
        push_vid(16'h4321);
        cpu_req = 1'b1;
        cpu_addr = 12'h123;
        vid_req = 1'b1;
        vid_addr = 12'hE00;
        n = 0;
        seen = 1'b0;
        do begin
            step();
            n++;
            if (vid_ack) seen = 1'b1;
        end while (!cpu_ack && n < 40);
        check("sim_cpu_latency", n, 3);
        check("sim_vid_not_first", seen, 0);
        cpu_req = 1'b0;
        step();
        check("sim_vid_next", vid_ack, 1);
        check("sim_vid_base", mem_addr, 12'hE00);
        vid_req = 1'b0;
        vid_body(12'hE00);

        vid_burst(12'hFFE, 16'h8765);

        // Continuous CPU traffic against a held video request
        for (int i = 0; i < 16; i++) q_cpu.push_back(4'h9);
        push_vid(16'hEDCB);
        cpu_req = 1'b1;
        cpu_addr = 12'h010;
        vid_req = 1'b1;
        vid_addr = 12'hE40;
        cnt = 0;
        first = 0;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (vid_ack) begin
                cnt++;
                if (first == 0) first = s;
                vid_req = 1'b0;
            end
        end
        vid_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_grants", cnt, 1);
        check("starve_first", first, 9);
`else
        check("starve_grants", cnt, 0);
`endif
        n = 0;
        while (!cpu_ack && n < 20) begin
            step();
            n++;
        end
        check("starve_cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        q_cpu.delete();
        q_vid.delete();

        // Reset while beat 2 is on the video data port
        push_vid(16'h4321);
        vid_req = 1'b1;
        vid_addr = 12'hE00;
        step();
        check("rst_burst_ack", vid_ack, 1);
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("beat2_valid", vid_data_valid, 1);
        check("beat2_data", vid_data, 4'h3);
        q_vid.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", vid_data_valid, 0);
        check("mid_rst_data", vid_data, 0);
        check("mid_rst_done", vid_done, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_ack", vid_ack, 0);
        step();
        step();
        check("rst_hold_done", vid_done, 0);
        reset_n = 1'b1;
        step();
        vid_burst(12'hE00, 16'h4321);

        for (int i = 0; i < 3; i++) step();
        check("q_cpu_empty", q_cpu.size(), 0);
        check("q_vid_empty", q_vid.size(), 0);
        check("q_wr_empty", q_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
